// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// MULT/DIV results land after a fixed busy window; MTHI/MTLO write immediately.
module mult_div_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;

    // Result datapath, evaluated from the latched operands only.
    logic             is_div;
    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic             b_zero;
    logic [2*WIDTH-1:0] ea;
    logic [2*WIDTH-1:0] eb;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] den;
    logic [WIDTH-1:0] uq;
    logic [WIDTH-1:0] ur;
    logic [WIDTH-1:0] sq;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    always_comb begin
        is_div    = op_q[1];
        is_signed = ~op_q[0];
        a_neg     = is_signed & a_q[WIDTH-1];
        b_neg     = is_signed & b_q[WIDTH-1];
        b_zero    = (b_q == '0);

        ea   = {{WIDTH{a_neg}}, a_q};
        eb   = {{WIDTH{b_neg}}, b_q};
        prod = ea * eb;

        // Magnitude divide; most-negative / -1 wraps back to most-negative.
        a_mag = a_neg ? (~a_q + 1'b1) : a_q;
        b_mag = b_neg ? (~b_q + 1'b1) : b_q;
        den   = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
        uq    = a_mag / den;
        ur    = a_mag % den;
        sq    = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
        sr    = a_neg ? (~ur + 1'b1) : ur;

        res_hi = '0;
        res_lo = '0;
        unique case (1'b1)
            !is_div: begin
                res_hi = prod[2*WIDTH-1:WIDTH];
                res_lo = prod[WIDTH-1:0];
            end
            is_div && b_zero: begin
                res_hi = a_q;
                res_lo = '1;
            end
            is_div && !b_zero: begin
                res_hi = sr;
                res_lo = sq;
            end
            default: ;
        endcase
    end

    logic acc_md;
    logic acc_mthi;
    logic acc_mtlo;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        done_d  = 1'b0;

        acc_md   = start & ~op[2];
        acc_mthi = start & (op == OP_MTHI);
        acc_mtlo = start & (op == OP_MTLO);

        unique case (state_q)
            S_IDLE: begin
                unique case (1'b1)
                    acc_md: begin
                        op_d    = op[1:0];
                        a_d     = A;
                        b_d     = B;
                        cnt_d   = op[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                        state_d = S_BUSY;
                    end
                    acc_mthi: hi_d = A;
                    acc_mtlo: lo_d = A;
                    default: ;
                endcase
            end
            S_BUSY: begin
                if (cnt_q == CW'(1)) begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (is_div) begin
                        dz_d = b_zero;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q == S_BUSY);
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  WIDTH  32  operand and HI/LO width
  MUL_CYCLES  5  busy cycles for MULT/MULTU (>=1)
  DIV_CYCLES  10  busy cycles for DIV/DIVU (>=1)
REQ-002 Ports SHALL be (name direction width meaning), one clock; reset asynchronous, active-high:
  clk  in  1  clock, rising edge
  reset  in  1  async active-high reset
  start  in  1  request; sampled at rising clk
  op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others NOP
  A  in  WIDTH  operand A / MTHI-MTLO data
  B  in  WIDTH  operand B
  busy  out  1  multi-cycle op in flight
  done  out  1  one-cycle pulse, HI/LO just updated by MULT/DIV
  hi  out  WIDTH  HI register
  lo  out  WIDTH  LO register
  div_zero  out  1  sticky: last completed DIV/DIVU had B==0

Function
REQ-003 start SHALL be accepted only when busy==0; start while busy==1 is ignored (no state change, operands not sampled).
REQ-004 On an accepted MULT/MULTU/DIV/DIVU at edge k, A, B and op SHALL be latched, busy=1 after edge k, and a down-counter loaded with MUL_CYCLES or DIV_CYCLES.
REQ-005 busy SHALL stay 1 for exactly N cycles (N = loaded count); at edge k+N hi/lo SHALL take the result, busy=0, done=1 for exactly that one cycle.
REQ-006 hi/lo SHALL hold previous values throughout the busy window; no intermediate values visible.
REQ-007 MULT: {hi,lo} = signed 2*WIDTH product; MULTU: unsigned 2*WIDTH product.
REQ-008 DIVU: lo = A/B, hi = A%B unsigned.
REQ-009 DIV: quotient truncates toward zero, remainder takes dividend's sign (e.g. -7/2 -> lo=-3, hi=-1).
REQ-010 DIV with A = most-negative, B = -1: lo = most-negative, hi = 0.
REQ-011 DIV/DIVU with B==0: lo = all ones, hi = A, div_zero=1 at completion; a completed divide with B!=0 clears div_zero; MULT/MTHI/MTLO leave div_zero unchanged.
REQ-012 MTHI/MTLO accepted at edge k SHALL write A to hi/lo at edge k, no busy, no done; other register unchanged.
REQ-013 NOP op codes with start=1 SHALL have no effect.
REQ-014 Operands changing on A/B while busy SHALL not affect the result.
REQ-015 A new start is accepted in the same cycle done==1 (busy already 0), giving back-to-back ops with zero idle cycles.

Reset
REQ-016 reset=1 SHALL immediately (asynchronously) force busy=0, done=0, hi=0, lo=0, div_zero=0, counter=0.
REQ-017 reset asserted mid-operation SHALL abort it; no done pulse and no hi/lo update after release.
REQ-018 First start SHALL be accepted at the first rising edge with reset low.

Verification
REQ-019 MULT A=-3 (0xFFFFFFFD), B=5, WIDTH=32 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, done one cycle.
REQ-020 MULTU A=0xFFFFFFFF, B=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-021 DIV A=-7, B=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU A=7, B=0 -> lo=0xFFFFFFFF, hi=7, div_zero=1.
REQ-022 MTHI A=0x12345678 then start DIV during busy of a MULT -> hi=0x12345678 right after MTHI; ignored DIV leaves result equal to MULT result only.
REQ-023 Start DIV, assert reset at busy cycle 4 -> all outputs 0 immediately, no done after release; subsequent MULT 2*3 -> lo=6, hi=0.
REQ-024 Back-to-back: MULTU 4*4 then DIVU 9/2 started on the done cycle -> lo=16 then lo=4, hi=1, no idle cycle between busy windows.
